// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: load formats and the
// bit positions inside the writeBackControl bundle.
package wb_pkg;

    typedef enum logic [2:0] {
        LOAD_WORD   = 3'b000,
        LOAD_BYTE_S = 3'b001,
        LOAD_HALF_S = 3'b010,
        LOAD_BYTE_U = 3'b101,
        LOAD_HALF_U = 3'b110
    } loadFormat_t;

    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

endpackage

// File: rtl/load_aligner.sv
// Combinational load alignment: picks the addressed byte/half lane, extends
// it to 32 bits and flags accesses that are misaligned or use a reserved format.
module load_aligner
    import wb_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] memReadData,
    input  logic [2:0]  loadFormat,
    input  logic [1:0]  byteOffset,
    output logic [31:0] alignedData,
    output logic        misaligned
);

    logic [1:0]  byteLane;
    logic        halfLane;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Big-endian puts offset 0 in the most significant lane, so the lane index is inverted.
    assign byteLane = BIG_ENDIAN ? ~byteOffset    : byteOffset;
    assign halfLane = BIG_ENDIAN ? ~byteOffset[1] : byteOffset[1];
    assign loadByte = memReadData[{byteLane, 3'b000} +: 8];
    assign loadHalf = memReadData[{halfLane, 4'b0000} +: 16];

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        alignedData = memReadData;
        misaligned  = 1'b0;
        case (loadFormat)
            LOAD_WORD:   misaligned  = (byteOffset != 2'b00);
            LOAD_BYTE_S: alignedData = {{24{loadByte[7]}}, loadByte};
            LOAD_BYTE_U: alignedData = {24'h00_0000, loadByte};
            LOAD_HALF_S: begin
                alignedData = {{16{loadHalf[15]}}, loadHalf};
                misaligned  = byteOffset[0];
            end
            LOAD_HALF_U: begin
                alignedData = {16'h0000, loadHalf};
                misaligned  = byteOffset[0];
            end
            default:     misaligned  = 1'b1;
        endcase
    end

endmodule

// File: rtl/write_back_stage.sv
// MEM/WB pipeline register with write-back data selection, retired-instruction
// counting and misaligned-load reporting toward the register-file write port.
module write_back_stage
    import wb_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32,
    parameter bit BIG_ENDIAN     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      inValid,
    input  logic [1:0]                writeBackControl,
    input  logic [2:0]                loadFormat,
    input  logic [1:0]                byteOffset,
    input  logic [31:0]               memReadData,
    input  logic [31:0]               aluResult,
    input  logic [REG_ADDR_WIDTH-1:0] writeRegisterIn,
    output logic                      regWrite,
    output logic [REG_ADDR_WIDTH-1:0] writeRegister,
    output logic [31:0]               writeData,
    output logic                      alignError,
    output logic                      alignErrorSticky,
    output logic [COUNT_WIDTH-1:0]    retiredCount
);

    logic [31:0] alignedData;
    logic        alignerMisaligned;
    logic        misaligned;
    logic [31:0] selectedData;
    logic        validQ;
    logic        regWriteCtlQ;
    logic        suppressQ;

    load_aligner #(.BIG_ENDIAN(BIG_ENDIAN)) aligner (
        .memReadData (memReadData),
        .loadFormat  (loadFormat),
        .byteOffset  (byteOffset),
        .alignedData (alignedData),
        .misaligned  (alignerMisaligned)
    );

    // Alignment only matters when the load data is actually being written back.
    assign misaligned   = writeBackControl[WB_MEM_TO_REG] & alignerMisaligned;
    assign selectedData = writeBackControl[WB_MEM_TO_REG] ? alignedData : aluResult;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            validQ           <= 1'b0;
            regWriteCtlQ     <= 1'b0;
            suppressQ        <= 1'b0;
            writeRegister    <= '0;
            writeData        <= '0;
            alignError       <= 1'b0;
            alignErrorSticky <= 1'b0;
            retiredCount     <= '0;
        end else if (flush) begin
            validQ        <= 1'b0;
            regWriteCtlQ  <= 1'b0;
            suppressQ     <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            alignError    <= 1'b0;
        end else if (!stall) begin
            validQ           <= inValid;
            regWriteCtlQ     <= writeBackControl[WB_REG_WRITE];
            suppressQ        <= misaligned;
            writeRegister    <= writeRegisterIn;
            writeData        <= selectedData;
            alignError       <= inValid & misaligned;
            alignErrorSticky <= alignErrorSticky | (inValid & misaligned);
            if (inValid) begin
                retiredCount <= retiredCount + COUNT_WIDTH'(1);
            end
        end
    end

    // r0 is hard-wired, so a write to it is never requested.
    assign regWrite = validQ & regWriteCtlQ & ~suppressQ & (writeRegister != '0);

endmodule

// File: tb/tb_write_back_stage.sv
// Scoreboard bench for write_back_stage (COUNT_WIDTH=8 variant, big-endian).
module tb_write_back_stage;
    import wb_pkg::*;

    localparam int RW = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1, stall = 1'b0, flush = 1'b0, inValid = 1'b0;
    logic [1:0]    writeBackControl = 2'b00;
    logic [2:0]    loadFormat = 3'b000;
    logic [1:0]    byteOffset = 2'b00;
    logic [31:0]   memReadData = '0, aluResult = '0;
    logic [RW-1:0] writeRegisterIn = '0;
    logic          regWrite, alignError, alignErrorSticky;
    logic [RW-1:0] writeRegister;
    logic [31:0]   writeData;
    logic [CW-1:0] retiredCount;

    write_back_stage #(.REG_ADDR_WIDTH(RW), .COUNT_WIDTH(CW), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .inValid(inValid),
        .writeBackControl(writeBackControl), .loadFormat(loadFormat), .byteOffset(byteOffset),
        .memReadData(memReadData), .aluResult(aluResult), .writeRegisterIn(writeRegisterIn),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .alignError(alignError), .alignErrorSticky(alignErrorSticky), .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic [RW-1:0] wr;
        logic [31:0]   wd;
        logic          dataKnown;
        logic          ae;
        logic          aes;
        logic [CW-1:0] cnt;
    } expect_t;

    expect_t scoreboard[$];
    expect_t model = '0;
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference load alignment written from the big-endian lane description.
    task automatic alignModel(input logic [2:0] f, input logic [1:0] o, input logic [31:0] md,
                              output logic [31:0] data, output logic mis, output logic known);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(md >> (8 * (3 - int'(o))));
        h = o[1] ? md[15:0] : md[31:16];
        known = 1'b1;
        data  = md;
        mis   = 1'b0;
        case (f)
            3'b000: mis  = (o != 2'b00);
            3'b001: data = {{24{b[7]}}, b};
            3'b101: data = {24'h0, b};
            3'b010: begin data = {{16{h[15]}}, h}; mis = o[0]; end
            3'b110: begin data = {16'h0, h}; mis = o[0]; end
            default: begin mis = 1'b1; known = 1'b0; end
        endcase
    endtask

    // Drive one edge's worth of stimulus at the falling edge, predict, then compare after the edge.
    task automatic step(input string tag, input logic rs, input logic st, input logic fl,
                        input logic iv, input logic [1:0] w, input logic [2:0] f,
                        input logic [1:0] o, input logic [31:0] md, input logic [31:0] a,
                        input logic [RW-1:0] r);
        logic [31:0] ld;
        logic        mis, known;
        expect_t     e;
        reset = rs; stall = st; flush = fl; inValid = iv; writeBackControl = w;
        loadFormat = f; byteOffset = o; memReadData = md; aluResult = a; writeRegisterIn = r;
        alignModel(f, o, md, ld, mis, known);
        mis = mis & w[0];
        if (rs) begin
            model = '0;
            model.dataKnown = 1'b1;
        end else if (fl) begin
            model.rw = 1'b0; model.wr = '0; model.wd = '0; model.ae = 1'b0; model.dataKnown = 1'b1;
        end else if (!st) begin
            model.rw  = iv & w[1] & (r != 0) & ~mis;
            model.wr  = r;
            model.wd  = w[0] ? ld : a;
            model.dataKnown = ~w[0] | known;
            model.ae  = iv & mis;
            model.aes = model.aes | (iv & mis);
            if (iv) model.cnt = model.cnt + 1'b1;
        end
        scoreboard.push_back(model);
        @(posedge clk);
        #1;
        e = scoreboard.pop_front();
        check({tag, ".regWrite"}, 32'(regWrite), 32'(e.rw));
        check({tag, ".writeRegister"}, 32'(writeRegister), 32'(e.wr));
        if (e.dataKnown) check({tag, ".writeData"}, writeData, e.wd);
        check({tag, ".alignError"}, 32'(alignError), 32'(e.ae));
        check({tag, ".sticky"}, 32'(alignErrorSticky), 32'(e.aes));
        check({tag, ".count"}, 32'(retiredCount), 32'(e.cnt));
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        step("reset", 1, 0, 0, 0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 5'd0);

        // ALU write
        step("alu", 0, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0000_1234, 5'd5);
        check("alu.lit", writeData, 32'h0000_1234);
        check("alu.cnt1", 32'(retiredCount), 32'd1);

        // Signed / unsigned bytes, big-endian lanes
        step("bs0", 0, 0, 0, 1, 2'b11, 3'b001, 2'd0, 32'h80FF_7F01, 32'h0, 5'd3);
        check("bs0.lit", writeData, 32'hFFFF_FF80);
        step("bs1", 0, 0, 0, 1, 2'b11, 3'b001, 2'd1, 32'h80FF_7F01, 32'h0, 5'd3);
        check("bs1.lit", writeData, 32'hFFFF_FFFF);
        step("bs2", 0, 0, 0, 1, 2'b11, 3'b001, 2'd2, 32'h80FF_7F01, 32'h0, 5'd3);
        check("bs2.lit", writeData, 32'h0000_007F);
        step("bs3", 0, 0, 0, 1, 2'b11, 3'b001, 2'd3, 32'h80FF_7F01, 32'h0, 5'd3);
        check("bs3.lit", writeData, 32'h0000_0001);
        step("bu1", 0, 0, 0, 1, 2'b11, 3'b101, 2'd1, 32'h80FF_7F01, 32'h0, 5'd3);
        check("bu1.lit", writeData, 32'h0000_00FF);

        // Halves and misaligned loads
        step("hs2", 0, 0, 0, 1, 2'b11, 3'b010, 2'd2, 32'h8001_7FFE, 32'h0, 5'd4);
        check("hs2.lit", writeData, 32'h0000_7FFE);
        step("hs0", 0, 0, 0, 1, 2'b11, 3'b010, 2'd0, 32'h8001_7FFE, 32'h0, 5'd4);
        check("hs0.lit", writeData, 32'hFFFF_8001);
        step("hu2", 0, 0, 0, 1, 2'b11, 3'b110, 2'd0, 32'h8001_7FFE, 32'h0, 5'd4);
        step("hmis", 0, 0, 0, 1, 2'b11, 3'b010, 2'd1, 32'h8001_7FFE, 32'h0, 5'd4);
        check("hmis.ae", 32'(alignError), 32'd1);
        step("after", 0, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0000_0042, 5'd6);
        check("after.ae", 32'(alignError), 32'd0);
        step("wmis", 0, 0, 0, 1, 2'b11, 3'b000, 2'd2, 32'h1234_5678, 32'h0, 5'd6);
        step("rsvd", 0, 0, 0, 1, 2'b11, 3'b011, 2'd0, 32'h1234_5678, 32'h0, 5'd6);
        step("aluoff", 0, 0, 0, 1, 2'b10, 3'b111, 2'd1, 32'h1234_5678, 32'h0000_0077, 5'd6);
        step("bubble", 0, 0, 0, 0, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0000_0099, 5'd6);

        // r0 suppression
        step("r0", 0, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'hDEAD_BEEF, 5'd0);
        check("r0.lit", writeData, 32'hDEAD_BEEF);

        // Stall holds, stall+flush squashes
        step("cap7", 0, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0000_0700, 5'd7);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 0, 1, 2'b11, 3'b010, 2'd1, 32'hFFFF_FFFF, 32'hAAAA_5555, 5'(9 + i));
        check("stall.reg", 32'(writeRegister), 32'd7);
        step("stfl", 0, 1, 1, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h1111_2222, 5'd8);
        step("flmis", 0, 0, 1, 1, 2'b11, 3'b010, 2'd1, 32'h0, 32'h0, 5'd8);

        // Reset mid-stream during stall and flush, then counter wrap
        step("rst2", 1, 1, 1, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h5555_0000, 5'd9);
        check("rst2.sticky", 32'(alignErrorSticky), 32'd0);
        for (int i = 0; i < 255; i++)
            step("fill", 0, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'(i), 5'(1 + (i % 31)));
        check("fill.max", 32'(retiredCount), 32'h0000_00FF);
        step("wrap", 0, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0000_0ABC, 5'd10);
        check("wrap.zero", 32'(retiredCount), 32'd0);
        step("mis2", 0, 0, 0, 1, 2'b11, 3'b110, 2'd3, 32'h0, 32'h0, 5'd11);
        step("rst3", 1, 0, 0, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h1, 5'd12);
        check("rst3.data", writeData, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
